// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: merges memory waits, load-use, redirects and halt into
// per-stage enable/flush controls, and drains the pipe into a sticky halted state.
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_memop,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             redirect,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic mem_wait;
    logic load_use;

    assign mem_wait = exmem_memop && !dhit;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = idex_dREN && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_cnt_d = stall_cnt_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = 1'b0;

        if (RST) begin
            state_d     = StRun;
            drain_cnt_d = '0;
            stall_cnt_d = '0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_wait) begin
                        // Whole pipe frozen; held redirect/halt are taken on the dhit cycle.
                    end else if (halt_mem) begin
                        state_d     = StDrain;
                        drain_cnt_d = DrainInit;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                    end else if (redirect) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (!ihit || load_use) begin
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end

                    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_en    = 1'b1;
                    if (drain_cnt_q == '0) begin
                        state_d = StHalted;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end
                StHalted: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        state_q     <= state_d;
        drain_cnt_q <= drain_cnt_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle RUN vectors plus
// hand-written multi-cycle sequences (stall counting, freeze, drain, halt, reset, saturation).
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, exmem_memop, idex_dREN, ifid_uses_rt, redirect, halt_mem;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;

    logic        pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a;
    logic        ifid_flush_a, idex_flush_a, exmem_flush_a, halted_a;
    logic [15:0] stall_count_a;
    logic        pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
    logic        ifid_flush_b, idex_flush_b, exmem_flush_b, halted_b;
    logic [3:0]  stall_count_b;

    int tests  = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .exmem_memop(exmem_memop),
        .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .redirect(redirect), .halt_mem(halt_mem),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a), .exmem_en(exmem_en_a),
        .memwb_en(memwb_en_a), .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
        .exmem_flush(exmem_flush_a), .halted(halted_a), .stall_count(stall_count_a)
    );

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(1), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .exmem_memop(exmem_memop),
        .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .redirect(redirect), .halt_mem(halt_mem),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .exmem_en(exmem_en_b),
        .memwb_en(memwb_en_b), .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
        .exmem_flush(exmem_flush_b), .halted(halted_b), .stall_count(stall_count_b)
    );

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
    logic [7:0] ctl_a, ctl_b;
    assign ctl_a = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a,
                    ifid_flush_a, idex_flush_a, exmem_flush_a};
    assign ctl_b = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b,
                    ifid_flush_b, idex_flush_b, exmem_flush_b};

    localparam logic [7:0] CtlRun    = 8'hF8;
    localparam logic [7:0] CtlBubble = 8'h1A;
    localparam logic [7:0] CtlFreeze = 8'h00;
    localparam logic [7:0] CtlRedir  = 8'hFF;
    localparam logic [7:0] CtlHalt   = 8'h1E;
    localparam logic [7:0] CtlDrain  = 8'h0F;
    localparam logic [7:0] CtlReset  = 8'h07;

    typedef struct {
        logic       ihit, dhit, memop, dren;
        logic [4:0] idex_rt, rs, rt;
        logic       uses_rt, redirect;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b1; exmem_memop = 1'b0; idex_dREN = 1'b0;
        idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
        redirect = 1'b0; halt_mem = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        @(negedge CLK);
        check("reset_ctl_a", 32'(ctl_a), 32'(CtlReset));
        check("reset_halted_a", 32'(halted_a), 32'd0);
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rt);
        idex_dREN = 1'b1; idex_rt = rt; ifid_rs = rt; ifid_rt = 5'd7; ifid_uses_rt = 1'b0;
    endtask

    initial begin
        //          ihit  dhit  memop dren  idex_rt rs     rt     uses  redir exp
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b0, CtlRun};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd2,  5'd2,  5'd5,  1'b0, 1'b0, CtlBubble};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, CtlRun};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  5'd4,  5'd3,  1'b1, 1'b0, CtlBubble};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  5'd4,  5'd3,  1'b0, 1'b0, CtlRun};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd3,  5'd3,  5'd3,  1'b1, 1'b0, CtlRun};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b0, CtlBubble};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b0, CtlFreeze};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b0, CtlRun};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd6,  5'd6,  5'd0,  1'b0, 1'b1, CtlRedir};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b1, CtlFreeze};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b1, CtlRedir};

        RST = 1'b1;
        idle_inputs();
        next_cycle();
        do_reset();
        @(negedge CLK);
        check("post_reset_stall_a", 32'(stall_count_a), 32'd0);
        check("post_reset_halted_a", 32'(halted_a), 32'd0);
        check("post_reset_ctl_a", 32'(ctl_a), 32'(CtlRun));

        // Single-cycle RUN vectors
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            ihit = vecs[i].ihit; dhit = vecs[i].dhit; exmem_memop = vecs[i].memop;
            idex_dREN = vecs[i].dren; idex_rt = vecs[i].idex_rt; ifid_rs = vecs[i].rs;
            ifid_rt = vecs[i].rt; ifid_uses_rt = vecs[i].uses_rt; redirect = vecs[i].redirect;
            @(negedge CLK);
            check($sformatf("vec%0d_ctl", i), 32'(ctl_a), 32'(vecs[i].exp));
        end

        // Load-use: exactly one bubble, then the r0 case never stalls
        next_cycle();
        do_reset();
        set_load_use(5'd2);
        @(negedge CLK);
        check("lu_bubble", 32'(ctl_a), 32'(CtlBubble));
        next_cycle();
        idex_dREN = 1'b0;
        @(negedge CLK);
        check("lu_resume", 32'(ctl_a), 32'(CtlRun));
        check("lu_stall_count", 32'(stall_count_a), 32'd1);
        set_load_use(5'd0);
        @(negedge CLK);
        check("lu_r0_ctl", 32'(ctl_a), 32'(CtlRun));
        next_cycle();
        check("lu_r0_stall", 32'(stall_count_a), 32'd1);

        // Memory wait freezes everything, then the held load-use bubble issues
        do_reset();
        set_load_use(5'd9);
        exmem_memop = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("freeze%0d", i), 32'(ctl_a), 32'(CtlFreeze));
            next_cycle();
        end
        dhit = 1'b1;
        @(negedge CLK);
        check("freeze_release", 32'(ctl_a), 32'(CtlBubble));
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        check("freeze_stall_count", 32'(stall_count_a), 32'd4);

        // Redirect beats fetch wait and load-use, and is not a stall
        next_cycle();
        do_reset();
        set_load_use(5'd4);
        ihit = 1'b0; redirect = 1'b1;
        @(negedge CLK);
        check("redir_ctl", 32'(ctl_a), 32'(CtlRedir));
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        check("redir_stall", 32'(stall_count_a), 32'd0);

        // Halt and drain: dut_a drains 2 cycles, dut_b 1 cycle
        next_cycle();
        do_reset();
        halt_mem = 1'b1;
        @(negedge CLK);
        check("halt_ctl_a", 32'(ctl_a), 32'(CtlHalt));
        check("halt_ctl_b", 32'(ctl_b), 32'(CtlHalt));
        next_cycle();
        halt_mem = 1'b0;
        @(negedge CLK);
        check("drain1_ctl_a", 32'(ctl_a), 32'(CtlDrain));
        check("drain1_ctl_b", 32'(ctl_b), 32'(CtlDrain));
        check("drain1_halted_a", 32'(halted_a), 32'd0);
        next_cycle();
        @(negedge CLK);
        check("drain2_ctl_a", 32'(ctl_a), 32'(CtlDrain));
        check("drain2_halted_a", 32'(halted_a), 32'd0);
        check("drain2_halted_b", 32'(halted_b), 32'd1);
        check("drain2_ctl_b", 32'(ctl_b), 32'(CtlFreeze));
        next_cycle();
        @(negedge CLK);
        check("halted_a", 32'(halted_a), 32'd1);
        for (int i = 0; i < 100; i++) begin
            next_cycle();
            ihit = 1'($urandom); dhit = 1'($urandom); exmem_memop = 1'($urandom);
            idex_dREN = 1'($urandom); idex_rt = 5'($urandom); ifid_rs = 5'($urandom);
            ifid_rt = 5'($urandom); ifid_uses_rt = 1'($urandom);
            redirect = 1'($urandom); halt_mem = 1'($urandom);
            @(negedge CLK);
            check($sformatf("hold%0d", i), 32'({halted_a, halted_b, ctl_a}), 32'h300);
        end
        check("halt_stall_frozen", 32'(stall_count_a), 32'd1);

        // Reset from HALTED
        next_cycle();
        do_reset();
        @(negedge CLK);
        check("rst_halted_halted", 32'(halted_a), 32'd0);
        check("rst_halted_stall", 32'(stall_count_a), 32'd0);
        check("rst_halted_ctl", 32'(ctl_a), 32'(CtlRun));

        // Reset from mid-DRAIN
        halt_mem = 1'b1;
        next_cycle();
        halt_mem = 1'b0;
        @(negedge CLK);
        check("mid_drain_ctl", 32'(ctl_a), 32'(CtlDrain));
        next_cycle();
        do_reset();
        @(negedge CLK);
        check("rst_drain_ctl", 32'(ctl_a), 32'(CtlRun));
        check("rst_drain_stall", 32'(stall_count_a), 32'd0);
        next_cycle();
        @(negedge CLK);
        check("rst_drain_halted", 32'(halted_a), 32'd0);

        // Saturation of the 4-bit counter under a long fetch wait
        next_cycle();
        do_reset();
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) next_cycle();
        ihit = 1'b1;
        @(negedge CLK);
        check("sat_stall_b", 32'(stall_count_b), 32'd15);
        check("sat_stall_a", 32'(stall_count_a), 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
